acc_multich: RTL and testbench

ACC_MULTICH -- requirements
Module: acc_multich

---
 rtl/acc_multich_pkg.sv | 17 +
 rtl/acc_sat_unit.sv | 38 +++
 rtl/acc_multich.sv | 99 +++++++++
 tb/tb_acc_multich.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/acc_multich_pkg.sv
// acc_multich_pkg: shared mode encoding and sizing helpers for the multichannel accumulator.
package acc_multich_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        ACC_ADD   = 2'b00,
        ACC_SUB   = 2'b01,
        ACC_LOAD  = 2'b10,
        ACC_CLEAR = 2'b11
    } acc_mode_e;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_sat_unit.sv
// acc_sat_unit: combinational add/sub/load/clear with overflow detection and optional clamping.
module acc_sat_unit
    import acc_multich_pkg::*;
#(
    parameter int DATA_W   = 20,
    parameter int ACC_W    = 38,
    parameter int SATURATE = 1
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic [MODE_W-1:0]        i_mode,
    output logic signed [ACC_W-1:0]  o_res,
    output logic                     o_ovf
);

    localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] w_ext;
    logic [ACC_W:0]   w_acc1;
    logic [ACC_W:0]   w_op1;
    logic [ACC_W:0]   w_sum;
    logic             w_wide_ovf;

    assign w_ext  = {{(ACC_W-DATA_W){i_a[DATA_W-1]}}, i_a};
    assign w_acc1 = {i_acc[ACC_W-1], i_acc};
    assign w_op1  = {w_ext[ACC_W-1], w_ext};
    assign w_sum  = (i_mode == ACC_SUB) ? w_acc1 - w_op1 : w_acc1 + w_op1;
    // Out of range exactly when the extra top bit disagrees with the ACC_W sign bit
    assign w_wide_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign o_ovf      = ~i_mode[1] & w_wide_ovf;

    assign o_res = (i_mode == ACC_CLEAR)           ? '0 :
                   (i_mode == ACC_LOAD)            ? w_ext :
                   (w_wide_ovf && SATURATE != 0)   ? (w_sum[ACC_W] ? MIN_V : MAX_V) :
                                                     w_sum[ACC_W-1:0];

endmodule

// File: rtl/acc_multich.sv
// acc_multich: NUM_CH independent signed accumulators with per-channel sticky overflow flags.
module acc_multich
    import acc_multich_pkg::*;
#(
    parameter  int DATA_W   = 20,
    parameter  int ACC_W    = 38,
    parameter  int NUM_CH   = 4,
    parameter  int SATURATE = 1,
    localparam int CH_W     = ch_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_i,
    input  logic [CH_W-1:0]          ch_i,
    input  logic [MODE_W-1:0]        mode_i,
    input  logic signed [DATA_W-1:0] A,
    output logic signed [ACC_W-1:0]  P,
    output logic                     p_valid_o,
    output logic [CH_W-1:0]          p_ch_o,
    output logic [NUM_CH-1:0]        ovf_o,
    output logic                     err_o
);

    if (ACC_W < DATA_W + 1) begin : g_bad_acc_w
        $error("acc_multich: ACC_W must be at least DATA_W+1");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("acc_multich: NUM_CH must be within 1..16");
    end

    logic signed [ACC_W-1:0] r_acc [NUM_CH];
    logic [NUM_CH-1:0]       r_ovf;
    logic signed [ACC_W-1:0] r_p;
    logic [CH_W-1:0]         r_pch;
    logic                    r_pv;
    logic                    r_err;

    logic [(1<<CH_W)-1:0]    w_ch_ok;
    logic                    w_go;
    logic signed [ACC_W-1:0] w_acc_sel;
    logic signed [ACC_W-1:0] w_res;
    logic                    w_ovf;

    // Channel codes beyond NUM_CH are representable when NUM_CH is not a power of two
    for (genvar g = 0; g < (1 << CH_W); g++) begin : g_ch_ok
        assign w_ch_ok[g] = (g < NUM_CH);
    end

    assign w_go = valid_i & w_ch_ok[ch_i];

    always_comb begin
        w_acc_sel = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch_i == CH_W'(i)) w_acc_sel = r_acc[i];
    end

    acc_sat_unit #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_sat (
        .i_acc  (w_acc_sel),
        .i_a    (A),
        .i_mode (mode_i),
        .o_res  (w_res),
        .o_ovf  (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
            r_ovf <= '0;
            r_p   <= '0;
            r_pch <= '0;
            r_pv  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_pv  <= w_go;
            r_err <= valid_i & ~w_ch_ok[ch_i];
            if (w_go) begin
                r_p   <= w_res;
                r_pch <= ch_i;
            end
            // LOAD/CLEAR (mode bit 1 set) drop the sticky flag; ADD/SUB accumulate it
            for (int i = 0; i < NUM_CH; i++)
                if (w_go && ch_i == CH_W'(i)) begin
                    r_acc[i] <= w_res;
                    r_ovf[i] <= w_ovf | (~mode_i[1] & r_ovf[i]);
                end
        end
    end

    assign P         = r_p;
    assign p_valid_o = r_pv;
    assign p_ch_o    = r_pch;
    assign ovf_o     = r_ovf;
    assign err_o     = r_err;

endmodule

// File: tb/tb_acc_multich.sv
// tb_acc_multich: directed and model-checked vectors across four parameterisations of acc_multich.
module tb_acc_multich;
    import acc_multich_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic v [4];
    logic [1:0] ch [4];
    logic [1:0] md [4];
    logic signed [19:0] a [4];

    logic signed [37:0] p0, p3;
    logic signed [20:0] p1, p2;
    logic pv [4];
    logic [1:0] pch [4];
    logic err [4];
    logic [3:0] ovf0, ovf1, ovf2;
    logic [2:0] ovf3;

    int n_vec = 0;
    int n_bad = 0;
    longint mdl [4];

    always #5 clk = ~clk;

    acc_multich #(.DATA_W(20), .ACC_W(38), .NUM_CH(4), .SATURATE(1)) u0 (
        .clk(clk), .reset(reset), .valid_i(v[0]), .ch_i(ch[0]), .mode_i(md[0]), .A(a[0]),
        .P(p0), .p_valid_o(pv[0]), .p_ch_o(pch[0]), .ovf_o(ovf0), .err_o(err[0]));
    acc_multich #(.DATA_W(20), .ACC_W(21), .NUM_CH(4), .SATURATE(1)) u1 (
        .clk(clk), .reset(reset), .valid_i(v[1]), .ch_i(ch[1]), .mode_i(md[1]), .A(a[1]),
        .P(p1), .p_valid_o(pv[1]), .p_ch_o(pch[1]), .ovf_o(ovf1), .err_o(err[1]));
    acc_multich #(.DATA_W(20), .ACC_W(21), .NUM_CH(4), .SATURATE(0)) u2 (
        .clk(clk), .reset(reset), .valid_i(v[2]), .ch_i(ch[2]), .mode_i(md[2]), .A(a[2]),
        .P(p2), .p_valid_o(pv[2]), .p_ch_o(pch[2]), .ovf_o(ovf2), .err_o(err[2]));
    acc_multich #(.DATA_W(20), .ACC_W(38), .NUM_CH(3), .SATURATE(1)) u3 (
        .clk(clk), .reset(reset), .valid_i(v[3]), .ch_i(ch[3]), .mode_i(md[3]), .A(a[3]),
        .P(p3), .p_valid_o(pv[3]), .p_ch_o(pch[3]), .ovf_o(ovf3), .err_o(err[3]));

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic op(input int k, input logic [1:0] m, input logic [1:0] c, input logic signed [19:0] x);
        v[k] = 1'b1; md[k] = m; ch[k] = c; a[k] = x;
        @(posedge clk); #1;
        v[k] = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin v[k] = 1'b0; ch[k] = '0; md[k] = '0; a[k] = '0; end
        idle(); idle();
        chk("rst_p", p0, 0);
        chk("rst_pv", longint'(pv[0]), 0);
        chk("rst_pch", longint'(pch[0]), 0);
        chk("rst_ovf", longint'(ovf0), 0);
        chk("rst_err", longint'(err[0]), 0);
        reset = 1'b0;

        op(0, ACC_ADD, 2'd0, 20'sd5);
        chk("add1_p", p0, 5);
        chk("add1_pv", longint'(pv[0]), 1);
        chk("add1_pch", longint'(pch[0]), 0);
        op(0, ACC_ADD, 2'd0, 20'sd5);
        chk("add2_p", p0, 10);
        chk("add2_pv", longint'(pv[0]), 1);

        op(0, ACC_ADD, 2'd1, 20'sd7);
        chk("il1_p", p0, 7);
        chk("il1_pch", longint'(pch[0]), 1);
        op(0, ACC_SUB, 2'd2, 20'sd3);
        chk("il2_p", p0, -3);
        chk("il2_pch", longint'(pch[0]), 2);
        op(0, ACC_ADD, 2'd1, 20'sd7);
        chk("il3_p", p0, 14);
        idle();
        chk("idle_pv", longint'(pv[0]), 0);
        chk("idle_p", p0, 14);
        chk("idle_pch", longint'(pch[0]), 1);
        op(0, ACC_ADD, 2'd0, 20'sd0);
        chk("ch0_keep", p0, 10);
        op(0, ACC_LOAD, 2'd3, -20'sd100);
        chk("load_p", p0, -100);
        op(0, ACC_CLEAR, 2'd3, 20'sd55);
        chk("clear_p", p0, 0);

        op(1, ACC_LOAD, 2'd0, 20'sd524287);
        chk("s_load", p1, 524287);
        op(1, ACC_ADD, 2'd0, 20'sd524287);
        chk("s_add1", p1, 1048574);
        chk("s_ovf1", longint'(ovf1), 0);
        op(1, ACC_ADD, 2'd0, 20'sd1);
        chk("s_add2", p1, 1048575);
        chk("s_ovf2", longint'(ovf1), 0);
        op(1, ACC_ADD, 2'd0, 20'sd1);
        chk("s_sat_hi", p1, 1048575);
        chk("s_ovf3", longint'(ovf1), 1);
        op(1, ACC_LOAD, 2'd0, 20'sd0);
        chk("s_ld0", p1, 0);
        chk("s_ovf_clr", longint'(ovf1), 0);
        op(1, ACC_LOAD, 2'd1, -20'sd524288);
        op(1, ACC_SUB, 2'd1, 20'sd524287);
        chk("s_sub1", p1, -1048575);
        op(1, ACC_SUB, 2'd1, 20'sd2);
        chk("s_sat_lo", p1, -1048576);
        chk("s_ovf_lo", longint'(ovf1), 2);
        op(1, ACC_ADD, 2'd1, 20'sd1);
        chk("s_sticky_p", p1, -1048575);
        chk("s_sticky", longint'(ovf1), 2);
        op(1, ACC_CLEAR, 2'd1, 20'sd0);
        chk("s_clr_ovf", longint'(ovf1), 0);

        op(2, ACC_LOAD, 2'd0, 20'sd524287);
        op(2, ACC_ADD, 2'd0, 20'sd524287);
        chk("w_add1", p2, 1048574);
        op(2, ACC_ADD, 2'd0, 20'sd2);
        chk("w_wrap", p2, -1048576);
        chk("w_ovf", longint'(ovf2), 1);

        op(3, ACC_LOAD, 2'd2, 20'sd9);
        chk("e_load", p3, 9);
        op(3, ACC_ADD, 2'd3, 20'sd5);
        chk("e_err", longint'(err[3]), 1);
        chk("e_pv", longint'(pv[3]), 0);
        chk("e_p", p3, 9);
        idle();
        chk("e_err_drop", longint'(err[3]), 0);
        op(3, ACC_ADD, 2'd2, 20'sd0);
        chk("e_ch2", p3, 9);
        op(3, ACC_ADD, 2'd0, 20'sd0);
        chk("e_ch0", p3, 0);

        mdl[0] = 10; mdl[1] = 14; mdl[2] = -3; mdl[3] = 0;
        for (int i = 0; i < 32; i++) begin
            logic [1:0] c;
            logic m;
            logic signed [19:0] x;
            c = 2'($urandom_range(0, 3));
            m = 1'($urandom_range(0, 1));
            x = 20'($urandom);
            mdl[c] = m ? mdl[c] - longint'(x) : mdl[c] + longint'(x);
            op(0, {1'b0, m}, c, x);
            chk("rnd_p", p0, mdl[c]);
            chk("rnd_pch", longint'(pch[0]), longint'(c));
        end

        v[0] = 1'b1; md[0] = ACC_ADD; ch[0] = 2'd1; a[0] = 20'sd7;
        reset = 1'b1;
        idle();
        chk("rr_p", p0, 0);
        chk("rr_pv", longint'(pv[0]), 0);
        chk("rr_pch", longint'(pch[0]), 0);
        chk("rr_ovf", longint'(ovf0), 0);
        chk("rr_err", longint'(err[0]), 0);
        reset = 1'b0;
        v[0] = 1'b0;
        op(0, ACC_ADD, 2'd1, 20'sd5);
        chk("post_rst", p0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
